// File: rtl/rename_free_list_pkg.sv
// rtl/rename_free_list_pkg.sv - shared sizes, types and helpers for the rename free list
package rename_free_list_pkg;

    localparam int N_WAY         = 2;
    localparam int freelistdepth = 32;
    localparam int TABLE_ENTRIES = 64;
    localparam int DEPTH         = freelistdepth;
    localparam int PREG_W        = $clog2(TABLE_ENTRIES);
    localparam int IDX_W         = $clog2(DEPTH);
    // Pointers and the free count carry one bit beyond the index so that
    // "all free" (count == DEPTH) and "none free" (count == 0) are distinct.
    localparam int PTR_W         = IDX_W + 1;
    localparam int FIRST_PREG    = 32;

    typedef logic [PREG_W-1:0] preg_t;
    typedef logic [PTR_W-1:0]  ptr_t;

    // Everything rename and the ROB present to the free list in one cycle.
    typedef struct packed {
        logic [N_WAY-1:0]        alloc_req;
        logic [N_WAY-1:0]        free_en;
        preg_t [N_WAY-1:0]       free_preg;
        logic [N_WAY-1:0]        commit_alloc;
    } free_list_req_t;

    function automatic logic [1:0] popcount2(input logic [1:0] v);
        return {1'b0, v[0]} + {1'b0, v[1]};
    endfunction

endpackage

// File: rtl/rename_free_list_if.sv
// rtl/rename_free_list_if.sv - rename/ROB to free-list handshake bundle
//   req        : alloc_req, free_en, free_preg, commit_alloc (master drives)
//   flush      : mispredict recovery (master drives)
//   alloc_preg : granted IDs, lane-compacted (slave drives)
//   alloc_ok   : every requested lane can be granted (slave drives)
//   free_count, empty, full : speculative occupancy view (slave drives)
interface rename_free_list_if;
    import rename_free_list_pkg::*;

    free_list_req_t          req;
    logic                    flush;
    preg_t [N_WAY-1:0]       alloc_preg;
    logic                    alloc_ok;
    ptr_t                    free_count;
    logic                    empty;
    logic                    full;

    modport master (
        output req, flush,
        input  alloc_preg, alloc_ok, free_count, empty, full
    );

    modport slave (
        input  req, flush,
        output alloc_preg, alloc_ok, free_count, empty, full
    );

endinterface

// File: rtl/rename_free_list_ptr.sv
// rtl/rename_free_list_ptr.sv - wrap-bit circular pointer with 0/1/2 increment and load
//   clk, rst_n : clock, asynchronous active-low reset
//   inc        : amount to advance this edge (0, 1 or 2)
//   load       : replace the pointer with load_val (takes priority over inc)
//   load_val   : value to load
//   ptr        : current pointer, index bits plus wrap bit
module rename_free_list_ptr
    import rename_free_list_pkg::*;
#(
    parameter ptr_t RESET_VAL = '0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] inc,
    input  logic       load,
    input  ptr_t       load_val,
    output ptr_t       ptr
);

    // DEPTH is a power of two, so plain wrap-around addition over the full
    // width keeps the index modulo DEPTH and toggles the wrap bit for free.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= RESET_VAL;
        end else if (load) begin
            ptr <= load_val;
        end else begin
            ptr <= ptr + ptr_t'(inc);
        end
    end

endmodule

// File: rtl/rename_free_list.sv
// rtl/rename_free_list.sv - 2-way physical register free list with committed-head recovery
//   clk, rst_n : clock, asynchronous active-low reset
//   fl         : slave side of rename_free_list_if (alloc/free/commit/flush, grants, occupancy)
module rename_free_list
    import rename_free_list_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    rename_free_list_if.slave    fl
);

    preg_t            entries [DEPTH];
    ptr_t             head;
    ptr_t             tail;
    ptr_t             chead;

    logic [1:0]       n_alloc;
    logic [1:0]       n_free;
    logic [1:0]       n_commit;
    ptr_t             count;
    logic             grant;
    logic             free_ok;
    logic [IDX_W-1:0] head_idx;
    logic [IDX_W-1:0] tail_idx;
    logic [IDX_W-1:0] rd1_idx;
    logic [IDX_W-1:0] wr1_idx;
    ptr_t             restore_head;

    assign n_alloc  = popcount2(fl.req.alloc_req);
    assign n_free   = popcount2(fl.req.free_en);
    assign n_commit = popcount2(fl.req.commit_alloc);

    assign count    = tail - head;
    assign head_idx = head[IDX_W-1:0];
    assign tail_idx = tail[IDX_W-1:0];

    // Lanes are compacted: a lane that is idle does not consume a slot, so
    // lane 1 reads one slot further only when lane 0 is also allocating.
    assign rd1_idx  = head_idx + IDX_W'(fl.req.alloc_req[0]);
    assign wr1_idx  = tail_idx + IDX_W'(fl.req.free_en[0]);

    // All-or-nothing grant judged against registered occupancy only; IDs
    // freed this cycle become visible next cycle.
    assign grant    = !fl.flush && (ptr_t'(n_alloc) <= count);

    // Returning more IDs than there are empty slots would overwrite live
    // entries, so the whole group of returns is dropped in that case.
    assign free_ok  = ({1'b0, count} + (PTR_W+1)'(n_free)) <= (PTR_W+1)'(DEPTH);

    // Commits in the flush cycle retire first, then speculation rewinds.
    assign restore_head = chead + ptr_t'(n_commit);

    assign fl.alloc_preg[0] = entries[head_idx];
    assign fl.alloc_preg[1] = entries[rd1_idx];
    assign fl.alloc_ok      = grant;
    assign fl.free_count    = count;
    assign fl.empty         = (count == '0);
    assign fl.full          = (count == ptr_t'(DEPTH));

    rename_free_list_ptr #(.RESET_VAL(ptr_t'(0))) u_head (
        .clk      (clk),
        .rst_n    (rst_n),
        .inc      (grant ? n_alloc : 2'd0),
        .load     (fl.flush),
        .load_val (restore_head),
        .ptr      (head)
    );

    // Tail starts one full lap ahead of head: every slot holds a free ID.
    rename_free_list_ptr #(.RESET_VAL(ptr_t'(DEPTH))) u_tail (
        .clk      (clk),
        .rst_n    (rst_n),
        .inc      (free_ok ? n_free : 2'd0),
        .load     (1'b0),
        .load_val ('0),
        .ptr      (tail)
    );

    rename_free_list_ptr #(.RESET_VAL(ptr_t'(0))) u_chead (
        .clk      (clk),
        .rst_n    (rst_n),
        .inc      (n_commit),
        .load     (1'b0),
        .load_val ('0),
        .ptr      (chead)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries[i] <= preg_t'(FIRST_PREG + i);
            end
        end else if (free_ok) begin
            if (fl.req.free_en[0]) begin
                entries[tail_idx] <= fl.req.free_preg[0];
            end
            if (fl.req.free_en[1]) begin
                entries[wr1_idx] <= fl.req.free_preg[1];
            end
        end
    end

    a_no_free_overflow: assert property (
        @(posedge clk) disable iff (!rst_n) free_ok
    );

    a_chead_behind_head: assert property (
        @(posedge clk) disable iff (!rst_n) (ptr_t'(n_commit) <= ptr_t'(head - chead))
    );

endmodule

// File: tb/tb_rename_free_list.sv
// tb/tb_rename_free_list.sv - scoreboard bench for rename_free_list against a queue model
module tb_rename_free_list;
    import rename_free_list_pkg::*;

    logic clk;
    logic rst_n;

    rename_free_list_if intf ();

    rename_free_list dut (
        .clk   (clk),
        .rst_n (rst_n),
        .fl    (intf.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] req;
        logic       ok;
        logic       chk_preg;
        int         p0;
        int         p1;
        int         cnt;
    } exp_t;

    exp_t exp_q[$];
    int   free_q[$];   // free IDs in allocation order
    int   inflight[$]; // allocated, not yet committed, oldest first
    int   total;
    int   bad;

    function automatic int pc(input logic [1:0] v);
        return int'(v[0]) + int'(v[1]);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        free_q   = {};
        inflight = {};
        for (int i = 0; i < DEPTH; i++) free_q.push_back(FIRST_PREG + i);
    endtask

    function automatic exp_t make_exp(input logic [1:0] req, input logic fl);
        exp_t e;
        int   sz;
        sz         = free_q.size();
        e.req      = req;
        e.ok       = !fl && (pc(req) <= sz);
        e.chk_preg = e.ok;
        e.cnt      = sz;
        e.p0       = (sz > 0) ? free_q[0] : 0;
        e.p1       = req[0] ? ((sz > 1) ? free_q[1] : 0) : e.p0;
        return e;
    endfunction

    // One clock of stimulus: drive, record the expectation, advance the model.
    task automatic cycle(input logic [1:0] req, input logic [1:0] fen,
                         input int f0, input int f1,
                         input logic [1:0] cmt, input logic fl);
        exp_t e;
        @(posedge clk);
        #1;
        intf.req.alloc_req    = req;
        intf.req.free_en      = fen;
        intf.req.free_preg[0] = preg_t'(f0);
        intf.req.free_preg[1] = preg_t'(f1);
        intf.req.commit_alloc = cmt;
        intf.flush            = fl;
        e = make_exp(req, fl);
        exp_q.push_back(e);
        if (e.ok) begin
            for (int k = 0; k < pc(req); k++) inflight.push_back(free_q.pop_front());
        end
        if (fen[0]) free_q.push_back(f0);
        if (fen[1]) free_q.push_back(f1);
        for (int k = 0; k < pc(cmt); k++) void'(inflight.pop_front());
        if (fl) begin
            while (inflight.size() > 0) free_q.push_front(inflight.pop_back());
        end
    endtask

    task automatic idle_inputs();
        intf.req   = '0;
        intf.flush = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        idle_inputs();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    // Monitor: compares whatever the DUT presents against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("alloc_ok", int'(intf.alloc_ok), int'(e.ok));
                chk("free_count", int'(intf.free_count), e.cnt);
                chk("empty", int'(intf.empty), int'(e.cnt == 0));
                chk("full", int'(intf.full), int'(e.cnt == DEPTH));
                if (e.chk_preg && e.req[0]) chk("alloc_preg0", int'(intf.alloc_preg[0]), e.p0);
                if (e.chk_preg && e.req[1]) chk("alloc_preg1", int'(intf.alloc_preg[1]), e.p1);
            end
        end
    end

    initial begin
        logic [1:0] req, fen, cmt;
        logic       fl;
        int         room;
        exp_t       e;

        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        idle_inputs();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Reset image, then drain the whole list two at a time.
        cycle(2'b00, 2'b00, 0, 0, 2'b00, 1'b0);
        for (int i = 0; i < 16; i++) cycle(2'b11, 2'b00, 0, 0, 2'b00, 1'b0);
        cycle(2'b11, 2'b00, 0, 0, 2'b00, 1'b0);
        cycle(2'b01, 2'b00, 0, 0, 2'b00, 1'b0);
        // Returns into an empty list are not grantable until next cycle.
        cycle(2'b01, 2'b11, 5, 9, 2'b11, 1'b0);
        cycle(2'b01, 2'b00, 0, 0, 2'b00, 1'b0);
        cycle(2'b01, 2'b00, 0, 0, 2'b00, 1'b0);

        // Lane 1 alone takes the head entry.
        do_reset();
        cycle(2'b10, 2'b00, 0, 0, 2'b00, 1'b0);
        cycle(2'b00, 2'b00, 0, 0, 2'b00, 1'b0);

        // Flush with a commit in the same cycle.
        do_reset();
        for (int i = 0; i < 3; i++) cycle(2'b11, 2'b00, 0, 0, 2'b00, 1'b0);
        cycle(2'b00, 2'b00, 0, 0, 2'b11, 1'b0);
        cycle(2'b11, 2'b00, 0, 0, 2'b01, 1'b1);
        cycle(2'b01, 2'b00, 0, 0, 2'b00, 1'b0);

        // Random legal traffic; many laps of the pointers.
        for (int i = 0; i < 600; i++) begin
            req = 2'($urandom_range(0, 3));
            fl  = ($urandom_range(0, 19) == 0);
            cmt = 2'($urandom_range(0, 3));
            if (inflight.size() == 0) cmt = 2'b00;
            else if (inflight.size() == 1 && cmt == 2'b11) cmt = 2'b01;
            room = DEPTH - (free_q.size() + inflight.size() - pc(cmt));
            fen = 2'($urandom_range(0, 3));
            if (room <= 0) fen = 2'b00;
            else if (room == 1 && fen == 2'b11) fen = 2'b10;
            cycle(req, fen, int'($urandom_range(0, 63)), int'($urandom_range(0, 63)), cmt, fl);
        end

        // Asynchronous reset in the middle of traffic.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            cmt = (inflight.size() >= 2) ? 2'b01 : 2'b00;
            cycle(2'($urandom_range(0, 3)), 2'b00, 0, 0, cmt, 1'b0);
        end
        @(posedge clk);
        #2;
        intf.req   = '0;
        intf.req.alloc_req = 2'b11;
        intf.flush = 1'b0;
        rst_n      = 1'b0;
        model_reset();
        e = make_exp(2'b11, 1'b0);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        idle_inputs();
        rst_n = 1'b1;
        cycle(2'b11, 2'b00, 0, 0, 2'b00, 1'b0);
        cycle(2'b00, 2'b00, 0, 0, 2'b00, 1'b0);

        @(posedge clk);
        #1;
        idle_inputs();
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
        if (exp_q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
